fetch_pc_unit: RTL
==================

// Module: fetch_pc_unit
// PURPOSE
//  Fetch-stage controller: owns the PC register, issues instruction-memory reads, registers the IF/ID pipeline stage.
//  Drives PCF to the external PC+4 adder and takes PCPlus4F back as the sequential next PC.
//  Applies branch/jump redirects from Execute and stalls/flushes from the hazard unit.
//  Allows one outstanding imem request at a time; returns later than a redirect are discarded.
// PARAMETERS
//  RESET_PC  64'h0000_0000_8000_0000  PCF value after reset
//  NOP_INSTR 32'h0000_0013            InstrD value on reset/flush (addi x0,x0,0)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  PCF             out  64  current fetch PC (to PC+4 adder)
//  PCPlus4F        in   64  PCF+4 from adder
//  PCTargetE       in   64  redirect target from Execute
//  PCSrcE          in   1   redirect request (taken branch/jump)
//  StallF          in   1   hold fetch; issue no new request
//  StallD          in   1   hold IF/ID register
//  FlushD          in   1   clear IF/ID register to bubble
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  64  read address (= PCF)
//  imem_rsp_valid  in   1   read data valid (exactly one per accepted request, >=1 cycle later)
//  imem_rsp_data   in   32  instruction word
//  InstrD,PCD,PCPlus4D out 32/64/64  IF/ID register contents
//  ValidD          out  1   IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (async): PCF=RESET_PC, state=S_REQ, ValidD=0, InstrD=NOP_INSTR, PCD=PCPlus4D=0, hold buffer empty.
//  Priority (highest first): rst_n, PCSrcE, StallD/FlushD on IF/ID, StallF on request.
//  States:
//   S_REQ : imem_req_valid = !StallF & !PCSrcE. Address may change while not accepted (memory samples only on valid&ready).
//           valid&ready -> S_RSP, latch req_pc=PCF.
//           PCSrcE -> PCF<=PCTargetE, stay S_REQ.
//   S_RSP : req_valid=0. rsp_valid & !PCSrcE -> PCF<=PCPlus4F; then StallD=0 -> load IF/ID (InstrD=rsp_data, PCD=req_pc, PCPlus4D=req_pc+4, ValidD=1), go S_REQ.
//           StallD=1 -> store in hold buffer, go S_HOLD.
//           PCSrcE & !rsp_valid -> PCF<=PCTargetE, go S_DROP. PCSrcE & rsp_valid -> PCF<=PCTargetE, drop data, go S_REQ.
//   S_HOLD: req_valid=0. StallD=0 -> load IF/ID from hold buffer, go S_REQ.
//           PCSrcE -> PCF<=PCTargetE, discard buffer, go S_REQ.
//   S_DROP: req_valid=0. Wait for rsp_valid, discard it, go S_REQ. PCSrcE here -> PCF<=PCTargetE, stay S_DROP.
//  IF/ID register:
//   StallD=1 holds all fields (FlushD ignored while stalled).
//   Otherwise FlushD=1 -> ValidD=0, InstrD=NOP_INSTR.
//   Otherwise load if delivering, else bubble (ValidD=0, InstrD=NOP_INSTR).
//  PCF changes only on reset, a redirect, or response acceptance; StallF never alters PCF.
//  Arithmetic modulo 2^64: PCF=64'hFFFF_FFFF_FFFF_FFFC wraps to 0 via PCPlus4F; PCPlus4D wraps the same way.
//  Zero-wait memory (rsp one cycle after accept) sustains one instruction every 2 cycles.
//  Reset mid-transaction returns to S_REQ; a late imem response after reset is the memory's responsibility.
// TESTING
//  1 Reset release, ready=1, rsp 1 cycle later -> first req addr 0x80000000; InstrD valid with PCD=0x80000000; next req addr 0x80000004.
//  2 PCSrcE=1, PCTargetE=0x80000100 while in S_RSP, rsp 3 cycles later -> stale rsp dropped (ValidD stays 0); next req addr 0x80000100.
//  3 StallD=1 for 4 cycles when rsp 0x00A00093 arrives -> held in S_HOLD, no new req; InstrD=0x00A00093 one cycle after StallD drops.
//  4 StallF=1 in S_REQ for 3 cycles -> imem_req_valid=0, PCF unchanged; request resumes next cycle.
//  5 FlushD=1, StallD=0 with ValidD=1 -> next cycle ValidD=0, InstrD=0x00000013; FlushD with StallD=1 -> IF/ID unchanged.
//  6 PCF=64'hFFFF_FFFF_FFFF_FFFC fetch completes -> PCF=0, PCPlus4D=0; rst_n pulse mid-S_RSP -> PCF=RESET_PC, ValidD=0 asynchronously.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage controller: owns the PC, issues one instruction-memory read at a
// time, and registers the IF/ID pipeline stage. Redirects from Execute discard
// any in-flight or buffered fetch so stale instructions never reach Decode.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_REQ  | presenting PCF to imem, waiting for the request to be accepted
// S_RSP  | one request outstanding, waiting for its response
// S_HOLD | response captured in the hold buffer while Decode is stalled
// S_DROP | outstanding response belongs to a redirected-away path; discard it
`timescale 1ns/1ps

module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] PCF,
  input  logic [63:0] PCPlus4F,
  input  logic [63:0] PCTargetE,
  input  logic        PCSrcE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [63:0] PCD,
  output logic [63:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RSP  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  logic [31:0] instr_id_q, instr_id_d;
  logic [63:0] pc_id_q, pc_id_d;
  logic [63:0] pc4_id_q, pc4_id_d;
  logic        valid_id_q, valid_id_d;

  logic        deliver;
  logic [31:0] deliver_instr;

  // A redirect takes priority over issuing, so the old-path address is never sent.
  assign imem_req_valid = (state_q == S_REQ) && !StallF && !PCSrcE;
  assign imem_req_addr  = pc_q;
  assign PCF            = pc_q;

  assign InstrD   = instr_id_q;
  assign PCD      = pc_id_q;
  assign PCPlus4D = pc4_id_q;
  assign ValidD   = valid_id_q;

  // Fetch sequencing: next state, next PC, and whether an instruction reaches Decode.
  // req_pc_q is also the PC of the held instruction, since it only moves on accept.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    hold_instr_d  = hold_instr_q;
    deliver       = 1'b0;
    deliver_instr = imem_rsp_data;
    case (state_q)
      S_REQ: begin
        if (PCSrcE) begin
          pc_d = PCTargetE;
        end else if (imem_req_valid && imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = S_RSP;
        end
      end
      S_RSP: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          pc_d = PCPlus4F;
          if (!StallD) begin
            deliver = 1'b1;
            state_d = S_REQ;
          end else begin
            hold_instr_d = imem_rsp_data;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_d    = PCTargetE;
          state_d = S_REQ;
        end else if (!StallD) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        if (PCSrcE) begin
          pc_d = PCTargetE;
        end
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // IF/ID register: stall holds everything, flush beats a delivery, idle cycles insert bubbles.
  always_comb begin
    instr_id_d = instr_id_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    valid_id_d = valid_id_q;
    if (!StallD) begin
      if (deliver && !FlushD) begin
        instr_id_d = deliver_instr;
        pc_id_d    = req_pc_q;
        pc4_id_d   = req_pc_q + 64'd4;
        valid_id_d = 1'b1;
      end else begin
        instr_id_d = NOP_INSTR;
        valid_id_d = 1'b0;
      end
    end
  end

  // Fetch controller state and PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= 64'd0;
      hold_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_id_q <= NOP_INSTR;
      pc_id_q    <= 64'd0;
      pc4_id_q   <= 64'd0;
      valid_id_q <= 1'b0;
    end else begin
      instr_id_q <= instr_id_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      valid_id_q <= valid_id_d;
    end
  end

endmodule
